// File: rtl/mux4_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter for four requesters sharing one 4:1 mux.
//               It issues registered one-hot grants, drives the mux select,
//               limits how long one requester may hold the grant while others
//               wait, and registers the selected input onto out_data.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Hold limit at counter width; the legal range 1..15 fits in 4 bits.
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  // Round-robin search: scan r from index start upward, wrapping modulo 4.
  // Returns {found, winner}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] start);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [2:0] res;
    dbl = {r, r};
    rot = dbl[start +: 4];
    res = 3'b000;
    // Walk downward so the lowest rotated offset (closest to start) wins.
    for (int k = 3; k >= 0; k--) begin
      if (rot[k]) begin
        res = {1'b1, start + 2'(k)};
      end
    end
    return res;
  endfunction

  logic [3:0]       sel_mask;
  logic [3:0]       req_others;
  logic [2:0]       idle_pick;
  logic [2:0]       rel_pick;
  logic             owner_dropped;
  logic             at_limit;
  logic             release_grant;
  logic [WIDTH-1:0] mux_data;

  // Decision terms for the current owner and both search cases.
  always_comb begin
    sel_mask      = 4'b0001 << sel;
    req_others    = req & ~sel_mask;
    idle_pick     = rr_pick(req, ptr);
    rel_pick      = rr_pick(req_others, sel + 2'd1);
    owner_dropped = ~|(req & sel_mask);
    at_limit      = (cnt == HOLD_LIMIT);
    // A drop and a limit expiry on the same edge resolve identically.
    release_grant = owner_dropped | (at_limit & (|req_others));
  end

  // The shared 4:1 multiplexer driven by the registered select.
  always_comb begin
    mux_data = in_a;
    case (sel)
      2'd0:    mux_data = in_a;
      2'd1:    mux_data = in_b;
      2'd2:    mux_data = in_c;
      2'd3:    mux_data = in_d;
      default: mux_data = in_a;
    endcase
  end

  // Arbitration FSM with registered grant, select, busy, pointer and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      busy  <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            state <= GRANT;
            gnt   <= 4'b0001 << idle_pick[1:0];
            sel   <= idle_pick[1:0];
            busy  <= 1'b1;
            cnt   <= 4'd1;
            ptr   <= idle_pick[1:0] + 2'd1;
          end else begin
            gnt   <= 4'b0000;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (release_grant) begin
            if (rel_pick[2]) begin
              // Back-to-back handover: no idle cycle between owners.
              gnt   <= 4'b0001 << rel_pick[1:0];
              sel   <= rel_pick[1:0];
              busy  <= 1'b1;
              cnt   <= 4'd1;
              ptr   <= rel_pick[1:0] + 2'd1;
            end else begin
              // Nobody else waiting: go idle, select keeps its last value.
              state <= IDLE;
              gnt   <= 4'b0000;
              busy  <= 1'b0;
            end
          end else if (!at_limit) begin
            cnt <= cnt + 4'd1;
          end
          // At the limit with no competition the counter saturates.
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: captures the muxed source while a grant is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (state == GRANT);
      if (state == GRANT) begin
        out_data <= mux_data;
      end
    end
  end

endmodule

`default_nettype wire
